// File: rtl/fc_sched_pkg.sv
// Shared types for the ping-pong FC buffer scheduler.
package fc_sched_pkg;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RUN} wr_state_t;
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_RUN} fc_state_t;

  localparam int unsigned NUM_BANKS = 2;

endpackage

// File: rtl/fc_buffer_pingpong_scheduler.sv
// Two-bank FC buffer scheduler: the writer fills one bank while the FC engine drains the other,
// counting frames up to a programmed total.
module fc_buffer_pingpong_scheduler
  import fc_sched_pkg::*;
#(
  parameter int unsigned FRAME_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [FRAME_W-1:0]   frame_total,
  input  logic                 abort,
  output logic                 writer_en,
  output logic                 writer_bank,
  input  logic                 writer_done,
  output logic                 fc_start,
  output logic                 fc_bank,
  input  logic                 fc_done,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 busy,
  output logic                 all_done,
  output logic                 protocol_err
);

  wr_state_t            r_wst;
  fc_state_t            r_fst;
  logic [FRAME_W-1:0]   r_total;
  logic [FRAME_W-1:0]   r_wr_cnt;
  logic [FRAME_W-1:0]   r_rd_cnt;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [NUM_BANKS-1:0] r_bank_full;
  logic                 r_perr;

  logic                 w_wr_issue;
  logic                 w_fc_issue;
  logic                 w_fin;
  logic                 w_busy;
  logic                 w_start_acc;
  logic                 w_wr_ack;
  logic                 w_fc_ack;
  logic [NUM_BANKS-1:0] w_set;
  logic [NUM_BANKS-1:0] w_clr;

  // All outputs decode from registered state only.
  assign w_wr_issue  = (r_wst == W_WAIT) && (r_wr_cnt != r_total) && !r_bank_full[r_wr_ptr];
  assign w_fc_issue  = (r_fst == F_WAIT) && (r_rd_cnt != r_total) &&  r_bank_full[r_rd_ptr];
  assign w_fin       = (r_fst == F_WAIT) && (r_rd_cnt == r_total);
  assign w_busy      = (r_fst != F_IDLE) && !w_fin;
  assign w_start_acc = start && !abort && !w_busy;
  assign w_wr_ack    = writer_done && (r_wst == W_RUN);
  assign w_fc_ack    = fc_done && (r_fst == F_RUN);
  assign w_set       = w_wr_ack ? (NUM_BANKS'(1) << r_wr_ptr) : '0;
  assign w_clr       = w_fc_ack ? (NUM_BANKS'(1) << r_rd_ptr) : '0;

  assign writer_en    = w_wr_issue;
  assign writer_bank  = r_wr_ptr;
  assign fc_start     = w_fc_issue;
  assign fc_bank      = r_rd_ptr;
  assign bank_full    = r_bank_full;
  assign busy         = w_busy;
  assign all_done     = w_fin;
  assign protocol_err = r_perr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wst    <= W_IDLE;
      r_wr_cnt <= '0;
      r_wr_ptr <= 1'b0;
    end else if (abort) begin
      r_wst    <= W_IDLE;
      r_wr_cnt <= '0;
      r_wr_ptr <= 1'b0;
    end else if (w_start_acc) begin
      r_wst    <= W_WAIT;
      r_wr_cnt <= '0;
      r_wr_ptr <= 1'b0;
    end else begin
      unique case (r_wst)
        W_WAIT: begin
          if (r_wr_cnt == r_total) begin
            r_wst <= W_IDLE;
          end else if (!r_bank_full[r_wr_ptr]) begin
            r_wr_cnt <= r_wr_cnt + FRAME_W'(1);
            r_wst    <= W_RUN;
          end
        end
        W_RUN: begin
          if (writer_done) begin
            r_wr_ptr <= ~r_wr_ptr;
            r_wst    <= W_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fst    <= F_IDLE;
      r_rd_cnt <= '0;
      r_rd_ptr <= 1'b0;
      r_total  <= '0;
    end else if (abort) begin
      r_fst    <= F_IDLE;
      r_rd_cnt <= '0;
      r_rd_ptr <= 1'b0;
    end else if (w_start_acc) begin
      r_fst    <= F_WAIT;
      r_rd_cnt <= '0;
      r_rd_ptr <= 1'b0;
      r_total  <= frame_total;
    end else begin
      unique case (r_fst)
        F_WAIT: begin
          if (r_rd_cnt == r_total) begin
            r_fst <= F_IDLE;
          end else if (r_bank_full[r_rd_ptr]) begin
            r_fst <= F_RUN;
          end
        end
        F_RUN: begin
          if (fc_done) begin
            r_rd_ptr <= ~r_rd_ptr;
            r_rd_cnt <= r_rd_cnt + FRAME_W'(1);
            r_fst    <= F_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  // Both FSMs touch bank_full; set and clear are merged per bit so a same-cycle
  // writer_done and fc_done (always on different banks) both land.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bank_full <= '0;
    end else if (abort || w_start_acc) begin
      r_bank_full <= '0;
    end else begin
      r_bank_full <= (r_bank_full & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perr <= 1'b0;
    end else if (abort) begin
      r_perr <= r_perr;
    end else if (w_start_acc) begin
      r_perr <= 1'b0;
    end else if ((writer_done && !w_wr_ack) || (fc_done && !w_fc_ack)) begin
      r_perr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_buffer_pingpong_scheduler.sv
// Randomized scoreboard bench for the ping-pong FC buffer scheduler, using a frame-count reference model.
module tb_fc_buffer_pingpong_scheduler;

  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic [FW-1:0] frame_total = '0;
  logic          abort = 1'b0;
  logic          writer_en;
  logic          writer_bank;
  logic          writer_done = 1'b0;
  logic          fc_start;
  logic          fc_bank;
  logic          fc_done = 1'b0;
  logic [1:0]    bank_full;
  logic          busy;
  logic          all_done;
  logic          protocol_err;

  fc_buffer_pingpong_scheduler #(.FRAME_W(FW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .frame_total  (frame_total),
    .abort        (abort),
    .writer_en    (writer_en),
    .writer_bank  (writer_bank),
    .writer_done  (writer_done),
    .fc_start     (fc_start),
    .fc_bank      (fc_bank),
    .fc_done      (fc_done),
    .bank_full    (bank_full),
    .busy         (busy),
    .all_done     (all_done),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nprint = 0;

  // Reference model: frame counts only; frame k always lives in bank k%2.
  bit m_run = 0;
  bit m_perr = 0;
  int m_total = 0;
  int m_iss = 0;
  int m_wr = 0;
  int m_fst = 0;
  int m_cons = 0;
  int q_w[$];
  int q_f[$];

  int wr_cd = 0;
  int fc_cd = 0;
  int wlo = 2, whi = 2, flo = 2, fhi = 2;
  bit inj_fc = 0;
  bit mon_en = 0;
  int ad_count = 0;
  int simul_cnt = 0;
  int full2_cnt = 0;
  int wen_cnt = 0;
  int fcs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (nprint < 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      nprint++;
    end
  endtask

  // Writer and FC engine stand-ins; pulses are driven on the falling edge.
  always @(negedge clk) begin
    writer_done = 1'b0;
    fc_done     = 1'b0;
    if (wr_cd > 0) begin
      wr_cd--;
      if (wr_cd == 0) writer_done = 1'b1;
    end
    if (fc_cd > 0) begin
      fc_cd--;
      if (fc_cd == 0) fc_done = 1'b1;
    end
    if (inj_fc) begin
      fc_done = 1'b1;
      inj_fc  = 1'b0;
    end
  end

  task automatic monitor_step();
    logic [1:0] ebf;
    bit ew, ef, ead;
    if (abort) begin
      m_run = 0; m_iss = 0; m_wr = 0; m_fst = 0; m_cons = 0;
      q_w.delete(); q_f.delete();
      wr_cd = 0; fc_cd = 0;
    end else if (start) begin
      m_run = 1; m_total = int'(frame_total);
      m_iss = 0; m_wr = 0; m_fst = 0; m_cons = 0; m_perr = 0;
      wen_cnt = 0; fcs_cnt = 0;
      q_w.delete(); q_f.delete();
      for (int k = 0; k < m_total; k++) begin
        q_w.push_back(k % 2);
        q_f.push_back(k % 2);
      end
    end else begin
      if (writer_done && fc_done && m_iss > m_wr && m_fst > m_cons) simul_cnt++;
      if (writer_done) begin
        if (m_iss > m_wr) m_wr++;
        else m_perr = 1;
      end
      if (fc_done) begin
        if (m_fst > m_cons) m_cons++;
        else m_perr = 1;
      end
    end

    ew  = m_run && m_iss < m_total && m_iss == m_wr && (m_iss - m_cons) < 2;
    ef  = m_run && m_fst < m_total && m_fst == m_cons && m_wr > m_cons;
    ead = m_run && m_cons == m_total;
    ebf = 2'b00;
    if (m_run) for (int k = m_cons; k < m_wr; k++) ebf[k % 2] = 1'b1;
    if (ebf == 2'b11) full2_cnt++;

    chk("writer_en", 32'(writer_en), 32'(ew));
    chk("fc_start", 32'(fc_start), 32'(ef));
    chk("all_done", 32'(all_done), 32'(ead));
    chk("busy", 32'(busy), 32'(m_run && !ead));
    chk("bank_full", 32'(bank_full), 32'(ebf));
    chk("protocol_err", 32'(protocol_err), 32'(m_perr));

    if (writer_en) begin
      wen_cnt++;
      if (q_w.size() == 0) chk("writer_en_extra", 32'd1, 32'd0);
      else chk("writer_bank", 32'(writer_bank), 32'(q_w.pop_front()));
      m_iss++;
      wr_cd = $urandom_range(whi, wlo);
    end
    if (fc_start) begin
      fcs_cnt++;
      if (q_f.size() == 0) chk("fc_start_extra", 32'd1, 32'd0);
      else chk("fc_bank", 32'(fc_bank), 32'(q_f.pop_front()));
      m_fst++;
      fc_cd = $urandom_range(fhi, flo);
    end
    if (all_done) ad_count++;
    if (ead) m_run = 0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (mon_en) monitor_step();
  end

  task automatic wait_idle();
    int n = 0;
    while (m_run && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (m_run) chk("run_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_run(input int total, input int wl, input int wh, input int fl, input int fh,
                        input int inject_at);
    int ad0;
    wlo = wl; whi = wh; flo = fl; fhi = fh;
    ad0 = ad_count;
    @(negedge clk);
    frame_total = FW'(total);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (inject_at >= 0) begin
      repeat (inject_at) @(posedge clk);
      inj_fc = 1'b1;
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("all_done_once", 32'(ad_count - ad0), 32'd1);
    chk("writer_en_count", 32'(wen_cnt), 32'(total));
    chk("fc_start_count", 32'(fcs_cnt), 32'(total));
    chk("wr_queue_left", 32'(q_w.size()), 32'd0);
    chk("fc_queue_left", 32'(q_f.size()), 32'd0);
  endtask

  initial begin
    int ad0;
    int n;
    #2 rstn = 1'b0;
    #1;
    chk("rst_writer_en", 32'(writer_en), 32'd0);
    chk("rst_fc_start", 32'(fc_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_all_done", 32'(all_done), 32'd0);
    chk("rst_bank_full", 32'(bank_full), 32'd0);
    chk("rst_protocol_err", 32'(protocol_err), 32'd0);
    chk("rst_banks", 32'({writer_bank, fc_bank}), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;

    do_run(0, 2, 2, 2, 2, -1);
    do_run(4, 10, 10, 3, 3, -1);

    full2_cnt = 0;
    do_run(5, 2, 2, 20, 20, -1);
    chk("stall_both_full_seen", 32'(full2_cnt > 0), 32'd1);
    chk("final_rd_cnt", 32'(m_cons), 32'd5);

    simul_cnt = 0;
    do_run(4, 5, 5, 5, 5, -1);
    chk("simultaneous_done_seen", 32'(simul_cnt > 0), 32'd1);

    do_run(2, 10, 10, 3, 3, 3);
    chk("protocol_err_sticky", 32'(protocol_err), 32'd1);

    wlo = 3; whi = 3; flo = 4; fhi = 4;
    ad0 = ad_count;
    @(negedge clk);
    frame_total = FW'(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (m_cons < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_3", 32'(m_cons >= 3), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bank_full", 32'(bank_full), 32'd0);
    chk("abort_no_all_done", 32'(ad_count - ad0), 32'd0);

    do_run(2, 2, 6, 2, 6, -1);
    chk("protocol_err_cleared", 32'(protocol_err), 32'd0);

    for (int r = 0; r < 6; r++) begin
      do_run(int'($urandom_range(8, 1)), int'($urandom_range(4, 2)), int'($urandom_range(12, 4)),
             int'($urandom_range(4, 2)), int'($urandom_range(12, 4)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
